data_fifo: RTL and testbench
============================

# data_fifo

Synchronous byte FIFO on the producer end of the data-FIFO link: it buffers bytes from an upstream writer and serves them to the downstream consumer. The consumer pulls data with `fifo_request_data`, and the FIFO drives `fifo_data`, `fifo_empty` and `fifo_overflow` back. Single clock domain. Sits between the stimulus/ingress logic and the consuming DUT block.

## Interface
- `DEPTH`, default 16: number of entries; power of two, at least 4.
- `DATA_WIDTH`, default 8: byte width; the link is defined at 8.
- `ALMOST_FULL_LEVEL`, default 12: occupancy threshold; used only with `DATA_FIFO_ALMOST_FULL_EN`.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `write_enable`, in, 1: push `write_data` this cycle.
- `write_data`, in, DATA_WIDTH: byte to push.
- `fifo_request_data`, in, 1: consumer requests one byte.
- `fifo_data`, out, DATA_WIDTH: registered read data.
- `fifo_empty`, out, 1: no stored entries.
- `fifo_full`, out, 1: occupancy equals DEPTH.
- `fifo_overflow`, out, 1: sticky; a write was dropped.
- `fifo_count`, out, $clog2(DEPTH)+1: current occupancy.
- `fifo_almost_full`, out, 1: present only with `DATA_FIFO_ALMOST_FULL_EN`.

## Operation
- Storage is a circular buffer. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Occupancy is held in the `fifo_count` register. `fifo_empty` = (count==0) and `fifo_full` = (count==DEPTH), both decoded from registered count.
- Push is accepted when `write_enable` is high and either not full, or full with an accepted read in the same cycle.
- Pop is accepted when `fifo_request_data` is high and not empty. The head entry is loaded into `fifo_data` and the read pointer advances.
- Request while empty: ignored. `fifo_data` holds its value, no pointer moves, no error flag.
- Write while full with no accepted read: data is dropped, pointers and count are unchanged, and `fifo_overflow` is set to 1. It stays 1 until `rst`.
- Simultaneous push and pop: both are performed and count is unchanged.
- Push into an empty FIFO with a request in the same cycle: the push is accepted and the request is ignored. There is no fall-through.
- Count update: +1 on push only, -1 on pop only, otherwise unchanged. Count never exceeds DEPTH or goes below 0.
- `fifo_data` holds its last popped value when no pop occurs.
- Reset values: `fifo_data`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_overflow`=0, `fifo_count`=0, `fifo_almost_full`=0. Pointers are 0. Memory contents are not reset.
- `rst` asserted mid-operation discards all contents on that edge. `write_enable` and `fifo_request_data` in the reset cycle are ignored.

## Timing
- Read latency is 1 cycle: a request accepted at edge N makes the byte visible on `fifo_data` after edge N.
- Write-to-visible latency is 1 cycle: a byte written at edge N clears `fifo_empty` after edge N. The earliest pop is at edge N+1, with data after N+1.
- Flags and count update on the same edge as the push or pop that changes them.
- Back-to-back requests on consecutive cycles sustain one byte per cycle while not empty.
- There is no combinational path from inputs to outputs.

## Configuration
- `DATA_FIFO_ALMOST_FULL_EN` defined: adds the `fifo_almost_full` port, a registered output equal to (count >= ALMOST_FULL_LEVEL), updated on the same edge as count.
- Not defined: the port and its logic are absent, `ALMOST_FULL_LEVEL` is unused, and all other behaviour is identical.

## Structure
- Package `data_fifo_pkg` holds:
  - `DATA_FIFO_DATA_WIDTH` = 8;
  - typedef `data_fifo_byte_t` (logic [7:0]);
  - default depth constant.
- Sub-module `data_fifo_mem`: a register array with one write port and one registered read port, no reset. The top level holds pointers, count, flags and the output register.

## Test plan
- Reset then idle: `fifo_empty`=1, `fifo_count`=0, `fifo_data`=0x00, `fifo_overflow`=0.
- Write 0x11, 0x22, 0x33, then request three cycles back-to-back: `fifo_data` is 0x11, 0x22, 0x33 on consecutive cycles, and `fifo_empty`=1 after the third pop.
- Fill 16 entries (0x00..0x0F): `fifo_full`=1, `fifo_count`=16. A 17th write of 0xAA is dropped, `fifo_overflow`=1 and stays 1. Draining returns 0x00..0x0F with no 0xAA.
- Full FIFO, simultaneous write 0x55 and request: `fifo_data`=0x00, count stays 16, `fifo_overflow` stays 0, and 0x55 is read last.
- Empty FIFO, request with write 0x77 in the same cycle: `fifo_data` unchanged and count=1. Next-cycle request yields 0x77.
- Push 40 bytes through with interleaved pops to wrap pointers twice, then assert `rst` with 5 entries held: all outputs return to reset values.
- With `DATA_FIFO_ALMOST_FULL_EN` defined: the 12th write sets `fifo_almost_full`=1, and one pop back to 11 clears it.

Source files
------------

// File: rtl/data_fifo_pkg.sv
// rtl/data_fifo_pkg.sv - shared constants and types for the data FIFO
package data_fifo_pkg;

  localparam int DATA_FIFO_DATA_WIDTH    = 8;
  localparam int DATA_FIFO_DEFAULT_DEPTH = 16;

  typedef logic [7:0] data_fifo_byte_t;

endpackage

// File: rtl/data_fifo_mem.sv
// rtl/data_fifo_mem.sv - register-array storage, one write port, one registered read port
module data_fifo_mem
  import data_fifo_pkg::*;
#(
  parameter int DEPTH      = DATA_FIFO_DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DATA_FIFO_DATA_WIDTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read; same-address write in the same cycle returns the old entry.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_fifo.sv
// rtl/data_fifo.sv - synchronous byte FIFO (optional DATA_FIFO_ALMOST_FULL_EN adds fifo_almost_full)
module data_fifo
  import data_fifo_pkg::*;
#(
  parameter int DEPTH             = DATA_FIFO_DEFAULT_DEPTH,
  parameter int DATA_WIDTH        = DATA_FIFO_DATA_WIDTH,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    fifo_request_data,
  output logic [DATA_WIDTH-1:0]   fifo_data,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    fifo_overflow,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef DATA_FIFO_ALMOST_FULL_EN
  ,
  output logic                    fifo_almost_full
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_cfg
    $error("data_fifo: DEPTH must be a power of two >= 4 and ALMOST_FULL_LEVEL <= DEPTH");
  end

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  // fifo_data must read 0 until the first pop, but the memory read register has no reset.
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  push_ok, pop_ok, empty, full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop_ok  = fifo_request_data && !empty;
  assign push_ok = write_enable && (!full || pop_ok);

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    data_valid_d = data_valid_q || pop_ok;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    if (write_enable && !push_ok) overflow_d = 1'b1;
  end

  // Control state; reset discards all contents on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      data_valid_q <= data_valid_d;
    end
  end

  data_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_ok && !rst),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (write_data),
    .rd_en_i   (pop_ok && !rst),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign fifo_data     = data_valid_q ? rd_data : '0;
  assign fifo_empty    = empty;
  assign fifo_full     = full;
  assign fifo_overflow = overflow_q;
  assign fifo_count    = count_q;

`ifdef DATA_FIFO_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_CNT = CW'(ALMOST_FULL_LEVEL);
  logic almost_full_q;

  // Threshold flag tracks the next count so it moves on the same edge as occupancy.
  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= (count_d >= AF_CNT);
  end

  assign fifo_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_data_fifo.sv
// tb/tb_data_fifo.sv - directed table-driven bench for data_fifo
module tb_data_fifo;
  import data_fifo_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            write_enable;
  data_fifo_byte_t write_data;
  logic            fifo_request_data;
  data_fifo_byte_t fifo_data;
  logic            fifo_empty, fifo_full, fifo_overflow;
  logic [4:0]      fifo_count;
`ifdef DATA_FIFO_ALMOST_FULL_EN
  logic            fifo_almost_full;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_fifo dut (
    .clk               (clk),
    .rst               (rst),
    .write_enable      (write_enable),
    .write_data        (write_data),
    .fifo_request_data (fifo_request_data),
    .fifo_data         (fifo_data),
    .fifo_empty        (fifo_empty),
    .fifo_full         (fifo_full),
    .fifo_overflow     (fifo_overflow),
    .fifo_count        (fifo_count)
`ifdef DATA_FIFO_ALMOST_FULL_EN
    ,
    .fifo_almost_full  (fifo_almost_full)
`endif
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic [7:0] wd;
    logic       req;
    logic [7:0] exp_data;
    logic       exp_empty;
    logic       exp_full;
    logic [4:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic we, input logic [7:0] wd, input logic req);
    rst = r; write_enable = we; write_data = wd; fifo_request_data = req;
    @(posedge clk);
    #1;
    rst = 1'b0; write_enable = 1'b0; write_data = 8'h00; fifo_request_data = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic e,
                           input logic f, input logic [4:0] c, input logic o);
    check({tag, ".data"},  {24'h0, fifo_data},  {24'h0, d});
    check({tag, ".empty"}, {31'h0, fifo_empty}, {31'h0, e});
    check({tag, ".full"},  {31'h0, fifo_full},  {31'h0, f});
    check({tag, ".count"}, {27'h0, fifo_count}, {27'h0, c});
    check({tag, ".ovf"},   {31'h0, fifo_overflow}, {31'h0, o});
  endtask

  vec_t vecs [11];
  logic [7:0] model_q [$];
  logic [7:0] last_data;

  initial begin
    rst = 1'b1; write_enable = 1'b0; write_data = 8'h00; fifo_request_data = 1'b0;
    @(negedge clk);

    //          rst we  wd    req  data  emp full cnt ovf
    vecs[0]  = '{1, 0, 8'h00, 0, 8'h00, 1, 0, 5'd0, 0};
    vecs[1]  = '{0, 1, 8'h11, 0, 8'h00, 0, 0, 5'd1, 0};
    vecs[2]  = '{0, 1, 8'h22, 0, 8'h00, 0, 0, 5'd2, 0};
    vecs[3]  = '{0, 1, 8'h33, 0, 8'h00, 0, 0, 5'd3, 0};
    vecs[4]  = '{0, 0, 8'h00, 1, 8'h11, 0, 0, 5'd2, 0};
    vecs[5]  = '{0, 0, 8'h00, 1, 8'h22, 0, 0, 5'd1, 0};
    vecs[6]  = '{0, 0, 8'h00, 1, 8'h33, 1, 0, 5'd0, 0};
    vecs[7]  = '{0, 0, 8'h00, 1, 8'h33, 1, 0, 5'd0, 0};
    vecs[8]  = '{0, 1, 8'h77, 1, 8'h33, 0, 0, 5'd1, 0};
    vecs[9]  = '{0, 0, 8'h00, 1, 8'h77, 1, 0, 5'd0, 0};
    vecs[10] = '{1, 0, 8'h00, 0, 8'h00, 1, 0, 5'd0, 0};

    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].req);
      check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_empty,
                vecs[i].exp_full, vecs[i].exp_count, vecs[i].exp_ovf);
    end

    // Fill, overflow with 0xAA, drain.
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0);
    check_all("fill16", 8'h00, 0, 1, 5'd16, 0);
    cycle(0, 1, 8'hAA, 0);
    check_all("ovf_write", 8'h00, 0, 1, 5'd16, 1);
    cycle(0, 0, 8'h00, 0);
    check("ovf_sticky", {31'h0, fifo_overflow}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 8'h00, 1);
      check($sformatf("drain%0d", i), {24'h0, fifo_data}, i);
    end
    check_all("drained", 8'h0F, 1, 0, 5'd0, 1);
    cycle(0, 0, 8'h00, 1);
    check("no_aa", {24'h0, fifo_data}, 32'h0F);

    // Full FIFO, simultaneous write and read.
    cycle(1, 0, 8'h00, 0);
    check_all("rst2", 8'h00, 1, 0, 5'd0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0);
    cycle(0, 1, 8'h55, 1);
    check_all("full_rw", 8'h00, 0, 1, 5'd16, 0);
    for (int i = 1; i < 17; i++) begin
      cycle(0, 0, 8'h00, 1);
      check($sformatf("full_rw_drain%0d", i), {24'h0, fifo_data}, (i == 16) ? 32'h55 : i);
    end
    check_all("full_rw_end", 8'h55, 1, 0, 5'd0, 0);

    // 40 pushes with interleaved pops to wrap pointers, then reset with 5 held.
    cycle(1, 0, 8'h00, 0);
    last_data = 8'h00;
    for (int k = 0; k < 40; k++) begin
      logic req, pop;
      req = (k % 5) != 0;
      pop = req && (model_q.size() > 0);
      if (pop) last_data = model_q.pop_front();
      if (model_q.size() < 16) model_q.push_back(8'(8'h80 + k));
      cycle(0, 1, 8'(8'h80 + k), req);
      check($sformatf("wrap_data%0d", k), {24'h0, fifo_data}, {24'h0, last_data});
      check($sformatf("wrap_cnt%0d", k), {27'h0, fifo_count}, model_q.size());
    end
    while (model_q.size() > 5) begin
      last_data = model_q.pop_front();
      cycle(0, 0, 8'h00, 1);
      check("wrap_drain", {24'h0, fifo_data}, {24'h0, last_data});
    end
    check_all("held5", last_data, 0, 0, 5'd5, 0);
    cycle(1, 1, 8'hEE, 1);
    check_all("mid_rst", 8'h00, 1, 0, 5'd0, 0);
    cycle(0, 0, 8'h00, 0);
    check_all("post_rst", 8'h00, 1, 0, 5'd0, 0);

`ifdef DATA_FIFO_ALMOST_FULL_EN
    check("af_reset", {31'h0, fifo_almost_full}, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      cycle(0, 1, 8'(i), 0);
      check($sformatf("af_w%0d", i), {31'h0, fifo_almost_full}, (i >= 12) ? 32'd1 : 32'd0);
    end
    cycle(0, 0, 8'h00, 1);
    check("af_pop", {31'h0, fifo_almost_full}, 32'd0);
    check("af_pop_cnt", {27'h0, fifo_count}, 32'd11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
